aes_sub_stage: RTL and testbench
================================

# aes_sub_stage

Parametrised SubBytes/key-schedule pipeline stage for the AES datapath. It is the multi-cycle, area-scalable successor to the single-cycle round-1 stage. It substitutes the 128-bit state LANES bytes per cycle, expands the round key once per block, and carries the round number alongside. It connects to neighbouring stages through a valid/ready handshake instead of a bare enable/done pair.

## Interface
- LANES, default 4: S-box instances per cycle. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream block presented
- in_ready  out  1  stage can accept this cycle
- in_state  in  128  state; byte i = bits [127-8i -: 8], with byte 0 the MSB (FIPS-197 order)
- in_key  in  128  current round key
- in_num  in  4  round number, 1..10
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- out_state  out  128  SubBytes(in_state)
- out_key  out  128  keyExpansion(in_key, in_num)
- out_num  out  4  in_num passed through unchanged
- busy  out  1  substitution in progress (state SUB)

## Operation
- BEATS = 16/LANES. Chunk c covers bytes c·LANES to c·LANES+LANES-1.
- The FSM has three states:
  - **IDLE**: in_ready=1.
  - **SUB**: in_ready=0; substitutes one chunk per cycle; a counter cnt runs 1..BEATS-1.
  - **FULL**: out_valid=1; in_ready=out_ready, combinational.
- Acceptance happens when in_valid & in_ready. On that edge:
  - the working state register loads in_state with chunk 0 already substituted;
  - out_key is registered as keyExpansion(in_key, in_num), using the existing keyExpansion module;
  - out_num is registered;
  - cnt is set to 1;
  - next state is SUB if BEATS>1, otherwise FULL.
- SUB: each edge substitutes chunk cnt in place and increments cnt. When cnt==BEATS-1, next state is FULL.
- FULL: out_state, out_key and out_num stay stable until out_ready.
  - out_ready & !in_valid: go to IDLE.
  - out_ready & in_valid: accept the new block in the same edge (acceptance rules above).
- in_num is not range-checked. keyExpansion uses rcon[in_num] as defined in the package, with 0x00 for values outside 1..10.
- The out_* values are don't-care while out_valid=0.
- rst low at any time, including mid-SUB, aborts the block. The FSM goes to IDLE, cnt=0, and all data registers clear. No partial result is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=0, out_key=0, out_num=0, FSM=IDLE, cnt=0.
- Latency: a block accepted on edge T gives out_valid=1 in the cycle after edge T+BEATS-1, i.e. BEATS cycles after acceptance.
- Throughput with out_ready held high:
  - LANES=16: one block per cycle.
  - Otherwise: one block per BEATS cycles, with no dead cycle because FULL hands off directly to the next acceptance.
- Backpressure: out_valid never drops without out_ready. Output data must not change while out_valid & !out_ready.
- in_ready depends combinationally on out_ready only in FULL. No other combinational input→output paths exist.

## Structure
- Package aes_pkg contains:
  - the SBOX constant (256×8);
  - function sbox(byte);
  - the RCON table;
  - the state enum {IDLE, SUB, FULL};
  - function beats(LANES).
- Sub-module sbox_bank #(LANES): LANES parallel byte look-ups, purely combinational. It is instantiated once and fed by a chunk multiplexer selected by cnt, or by 0 at acceptance.
- keyExpansion is reused unchanged.

## Test plan
- FIPS-197 vector, LANES=4: in_state=00102030405060708090a0b0c0d0e0f0, in_key=000102030405060708090a0b0c0d0e0f, in_num=1. Expect out_state=63cab7040953d051cd60e0e7ba70e18c, out_key=d6aa74fdd2af72fadaa678f1d6ab76fe, out_num=1, with out_valid exactly 4 cycles after acceptance.
- Zero vector, all LANES values: state=0, key=0, num=1. Expect state 6363…63 (16 bytes), key=62636363626363636263636362636363. Latency must equal 16, 8, 4, 2, 1 cycles.
- Back-to-back, LANES=16, out_ready=1: 8 random blocks on consecutive cycles. Expect 8 consecutive out_valid cycles, results in order and matching the model.
- Backpressure: hold out_ready=0 for 5 cycles while in FULL with in_valid=1. Expect in_ready=0 and out_* constant. Release out_ready; the next block is accepted on that same edge.
- Reset mid-SUB, LANES=1: assert rst low at cnt=7. Expect immediate out_valid=0, busy=0, in_ready=1 and outputs 0. The next block after release produces a correct result.
- Out-of-range in_num=0 and in_num=12: expect out_key computed with rcon=0x00, and out_num echoed unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, S-box/RCON look-ups and the sub-stage FSM encoding.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, SUB, FULL} state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entries outside rounds 1..10 are zero so out-of-range round numbers stay harmless.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        return RCON[n];
    endfunction

    function automatic int beats(input int lanes);
        return 16 / lanes;
    endfunction

endpackage

// File: rtl/keyExpansion.sv
// One AES-128 key-schedule step: next round key from the current key and round number.
module keyExpansion
    import aes_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [3:0]   i_num,
    output logic [127:0] o_key
);

    logic [31:0] w_rot;
    logic [31:0] w_temp;
    logic [31:0] w_k0, w_k1, w_k2, w_k3;

    assign w_rot  = {i_key[23:0], i_key[31:24]};
    assign w_temp = {sbox(w_rot[31:24]) ^ rcon(i_num), sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]), sbox(w_rot[7:0])};

    assign w_k0  = i_key[127:96] ^ w_temp;
    assign w_k1  = w_k0 ^ i_key[95:64];
    assign w_k2  = w_k1 ^ i_key[63:32];
    assign w_k3  = w_k2 ^ i_key[31:0];
    assign o_key = {w_k0, w_k1, w_k2, w_k3};

endmodule

// File: rtl/sbox_bank.sv
// LANES independent, purely combinational S-box look-ups.
module sbox_bank
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [8*LANES-1:0] i_bytes,
    output logic [8*LANES-1:0] o_bytes
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign o_bytes[8*gi +: 8] = sbox(i_bytes[8*gi +: 8]);
        end
    endgenerate

endmodule

// File: rtl/aes_sub_stage.sv
// Multi-cycle SubBytes + key-schedule stage: LANES bytes substituted per cycle,
// valid/ready on both sides, result held in FULL until taken downstream.
module aes_sub_stage
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic [3:0]   in_num,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [127:0] out_key,
    output logic [3:0]   out_num,
    output logic         busy
);

    localparam int         BEATS = beats(LANES);
    localparam int         CW    = 8 * LANES;
    localparam logic [3:0] LAST  = 4'(BEATS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_sub_stage: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_e         r_fsm, w_fsm_next;
    logic [3:0]     r_cnt;
    logic [127:0]   r_state, r_key;
    logic [3:0]     r_num;

    logic           w_acc;
    logic [3:0]     w_sel;
    logic [127:0]   w_src, w_sub_state, w_key_exp;
    logic [CW-1:0]  w_chunk, w_chunk_sub;

    assign w_acc = in_valid & in_ready;
    // Acceptance substitutes chunk 0 straight from the input bus.
    assign w_sel = w_acc ? 4'd0 : r_cnt;
    assign w_src = w_acc ? in_state : r_state;

    always_comb begin
        w_chunk = '0;
        for (int c = 0; c < BEATS; c++) begin
            if (w_sel == 4'(c)) w_chunk = w_src[128 - CW*(c+1) +: CW];
        end
    end

    sbox_bank #(.LANES(LANES)) u_sbox_bank (
        .i_bytes (w_chunk),
        .o_bytes (w_chunk_sub)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign w_sub_state[127-8*gi -: 8] = (w_sel == 4'(gi / LANES))
                ? w_chunk_sub[CW-1-8*(gi % LANES) -: 8]
                : w_src[127-8*gi -: 8];
        end
    endgenerate

    keyExpansion u_key_exp (
        .i_key (in_key),
        .i_num (in_num),
        .o_key (w_key_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fsm <= IDLE;
        else      r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE: if (w_acc) w_fsm_next = (BEATS > 1) ? SUB : FULL;
            SUB:  if (r_cnt == LAST) w_fsm_next = FULL;
            FULL: begin
                if (w_acc)          w_fsm_next = (BEATS > 1) ? SUB : FULL;
                else if (out_ready) w_fsm_next = IDLE;
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            IDLE: in_ready = 1'b1;
            SUB:  busy     = 1'b1;
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_num   <= '0;
            r_cnt   <= '0;
        end else if (w_acc) begin
            r_state <= w_sub_state;
            r_key   <= w_key_exp;
            r_num   <= in_num;
            r_cnt   <= 4'd1;
        end else if (r_fsm == SUB) begin
            r_state <= w_sub_state;
            r_cnt   <= r_cnt + 4'd1;
        end
    end

    assign out_state = r_state;
    assign out_key   = r_key;
    assign out_num   = r_num;

endmodule

// File: tb/tb_aes_sub_stage.sv
// Directed bench for aes_sub_stage: one instance per legal LANES value on shared inputs.
`timescale 1ns/1ps
module tb_aes_sub_stage;

    localparam int NI = 5;   // instance i has LANES = 1<<i

    localparam logic [127:0] FIPS_S  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_SO = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] FIPS_KO = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] FIPS_K0 = 128'hd7aa74fdd3af72fadba678f1d7ab76fe;
    localparam logic [127:0] ZERO_SO = {16{8'h63}};
    localparam logic [127:0] ZERO_KO = 128'h62636363626363636263636362636363;

    localparam logic [0:7][7:0] B2B_IN  = {8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
    localparam logic [0:7][7:0] B2B_OUT = {8'h63, 8'hca, 8'hb7, 8'h04, 8'h09, 8'h53, 8'hd0, 8'h51};
    localparam logic [0:7][7:0] B2B_KB  = {8'h62, 8'h61, 8'h67, 8'h6b, 8'h73, 8'h43, 8'h23, 8'he3};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic [127:0] in_key = '0;
    logic [3:0]   in_num = '0;

    logic         ir [NI];
    logic         ov [NI];
    logic         bz [NI];
    logic [127:0] os [NI];
    logic [127:0] ok [NI];
    logic [3:0]   on [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            aes_sub_stage #(.LANES(1 << gi)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (ir[gi]),
                .in_state  (in_state),
                .in_key    (in_key),
                .in_num    (in_num),
                .out_valid (ov[gi]),
                .out_ready (out_ready),
                .out_state (os[gi]),
                .out_key   (ok[gi]),
                .out_num   (on[gi]),
                .busy      (bz[gi])
            );
        end
    endgenerate

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Counts negedges (first one = acceptance edge) until instance idx shows out_valid; 999 on timeout.
    task automatic wait_valid(input int idx, input bit drop_valid, output int lat);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (drop_valid) in_valid = 1'b0;
            lat++;
            if (ov[idx] === 1'b1) return;
        end
        lat = 999;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++; if (ir[i] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, ir[i]); end
            checks++; if (ov[i] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, ov[i]); end
            checks++; if (bz[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, bz[i]); end
            checks++; if ({os[i], ok[i], on[i]} !== 260'd0) begin
                failures++; $display("FAIL reset_data[%0d] got=%h/%h/%h exp=0", i, os[i], ok[i], on[i]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_fips();
        int lat;
        do_reset();
        in_state = FIPS_S; in_key = FIPS_K; in_num = 4'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        checks++; if (bz[2] !== 1'b1 || ov[2] !== 1'b0) begin
            failures++; $display("FAIL fips_busy got busy=%b valid=%b exp busy=1 valid=0", bz[2], ov[2]);
        end
        while (ov[2] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== 4) begin failures++; $display("FAIL fips_latency got=%0d exp=4", lat); end
        checks++; if (os[2] !== FIPS_SO) begin failures++; $display("FAIL fips_state got=%h exp=%h", os[2], FIPS_SO); end
        checks++; if (ok[2] !== FIPS_KO) begin failures++; $display("FAIL fips_key got=%h exp=%h", ok[2], FIPS_KO); end
        checks++; if (on[2] !== 4'd1) begin failures++; $display("FAIL fips_num got=%0d exp=1", on[2]); end
        $display("fips: lat=%0d state=%h key=%h", lat, os[2], ok[2]);
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (ov[2] !== 1'b0) begin failures++; $display("FAIL fips_release got=%b exp=0", ov[2]); end
        out_ready = 1'b0;
    endtask

    task automatic test_zero_all();
        int lat [NI];
        logic [127:0] cs [NI];
        logic [127:0] ck [NI];
        do_reset();
        for (int i = 0; i < NI; i++) begin lat[i] = 999; cs[i] = 'x; ck[i] = 'x; end
        in_state = '0; in_key = '0; in_num = 4'd1; in_valid = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (lat[i] == 999 && ov[i] === 1'b1) begin lat[i] = n; cs[i] = os[i]; ck[i] = ok[i]; end
            end
        end
        for (int i = 0; i < NI; i++) begin
            checks++; if (lat[i] !== (16 >> i)) begin failures++; $display("FAIL zero_latency[L=%0d] got=%0d exp=%0d", 1 << i, lat[i], 16 >> i); end
            checks++; if (cs[i] !== ZERO_SO) begin failures++; $display("FAIL zero_state[L=%0d] got=%h exp=%h", 1 << i, cs[i], ZERO_SO); end
            checks++; if (ck[i] !== ZERO_KO) begin failures++; $display("FAIL zero_key[L=%0d] got=%h exp=%h", 1 << i, ck[i], ZERO_KO); end
            $display("zero: LANES=%0d lat=%0d", 1 << i, lat[i]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] es, ek;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_state = {16{B2B_IN[k]}}; in_key = '0; in_num = 4'(k + 1); in_valid = 1'b1;
            @(negedge clk);
            es = {16{B2B_OUT[k]}};
            ek = {4{B2B_KB[k], 24'h636363}};
            checks++; if (ov[4] !== 1'b1 || ir[4] !== 1'b1) begin
                failures++; $display("FAIL b2b_handshake[%0d] got valid=%b ready=%b exp 1/1", k, ov[4], ir[4]);
            end
            checks++; if (os[4] !== es) begin failures++; $display("FAIL b2b_state[%0d] got=%h exp=%h", k, os[4], es); end
            checks++; if (ok[4] !== ek || on[4] !== 4'(k + 1)) begin
                failures++; $display("FAIL b2b_key[%0d] got=%h/%0d exp=%h/%0d", k, ok[4], on[4], ek, k + 1);
            end
            $display("b2b: block %0d state=%h key=%h num=%0d", k, os[4], ok[4], on[4]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (ov[4] !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", ov[4]); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        do_reset();
        in_state = FIPS_S; in_key = FIPS_K; in_num = 4'd1; in_valid = 1'b1;
        @(negedge clk);
        in_state = '0; in_key = '0; in_num = 4'd3;
        wait_valid(2, 1'b0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_first_latency got=%0d exp=3", lat); end
        for (int r = 0; r < 5; r++) begin
            checks++; if (ir[2] !== 1'b0 || ov[2] !== 1'b1) begin
                failures++; $display("FAIL bp_hold_handshake[%0d] got ready=%b valid=%b exp 0/1", r, ir[2], ov[2]);
            end
            checks++; if (os[2] !== FIPS_SO || ok[2] !== FIPS_KO || on[2] !== 4'd1) begin
                failures++; $display("FAIL bp_hold_data[%0d] got=%h/%h/%0d", r, os[2], ok[2], on[2]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (ir[2] !== 1'b1) begin failures++; $display("FAIL bp_ready_comb got=%b exp=1", ir[2]); end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (ov[2] !== 1'b0 || bz[2] !== 1'b1) begin
            failures++; $display("FAIL bp_handoff got valid=%b busy=%b exp 0/1", ov[2], bz[2]);
        end
        wait_valid(2, 1'b1, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_second_latency got=%0d exp=3", lat); end
        checks++; if (os[2] !== ZERO_SO || ok[2] !== {4{32'h67636363}} || on[2] !== 4'd3) begin
            failures++; $display("FAIL bp_second_data got=%h/%h/%0d", os[2], ok[2], on[2]);
        end
        $display("backpressure: second block state=%h key=%h", os[2], ok[2]);
    endtask

    task automatic test_reset_mid_sub();
        int lat;
        do_reset();
        in_state = FIPS_S; in_key = FIPS_K; in_num = 4'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (bz[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", bz[0]); end
        rst = 1'b0;
        #1;
        checks++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
            failures++; $display("FAIL rst_mid_ctrl got valid=%b busy=%b ready=%b exp 0/0/1", ov[0], bz[0], ir[0]);
        end
        checks++; if ({os[0], ok[0], on[0]} !== 260'd0) begin
            failures++; $display("FAIL rst_mid_data got=%h/%h/%h exp=0", os[0], ok[0], on[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in_state = '0; in_key = '0; in_num = 4'd2; in_valid = 1'b1;
        wait_valid(0, 1'b1, lat);
        checks++; if (lat !== 16) begin failures++; $display("FAIL rst_mid_after_latency got=%0d exp=16", lat); end
        checks++; if (os[0] !== ZERO_SO || ok[0] !== {4{32'h61636363}} || on[0] !== 4'd2) begin
            failures++; $display("FAIL rst_mid_after_data got=%h/%h/%0d", os[0], ok[0], on[0]);
        end
        $display("reset_mid_sub: recovered lat=%0d", lat);
    endtask

    task automatic test_num_range();
        int lat;
        logic [3:0] num;
        for (int j = 0; j < 2; j++) begin
            num = (j == 0) ? 4'd0 : 4'd12;
            do_reset();
            in_state = FIPS_S; in_key = FIPS_K; in_num = num; in_valid = 1'b1;
            wait_valid(2, 1'b1, lat);
            checks++; if (lat !== 4) begin failures++; $display("FAIL num_latency[%0d] got=%0d exp=4", num, lat); end
            checks++; if (ok[2] !== FIPS_K0) begin failures++; $display("FAIL num_key[%0d] got=%h exp=%h", num, ok[2], FIPS_K0); end
            checks++; if (on[2] !== num) begin failures++; $display("FAIL num_echo[%0d] got=%0d", num, on[2]); end
            checks++; if (os[2] !== FIPS_SO) begin failures++; $display("FAIL num_state[%0d] got=%h exp=%h", num, os[2], FIPS_SO); end
            $display("num_range: num=%0d key=%h", num, ok[2]);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_all();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_sub();
        test_num_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
